// File: rtl/combiner_sweep_ctrl.sv
// Acquisition sequencer for the combiner phase loop.
// Generates a triangular phase-sweep offset, qualifies lock from the real/imag
// detectors with lock/unlock dwell counts, and freezes the sweep while locked.
module combiner_sweep_ctrl (
    input  logic        clk,
    input  logic        nReset,
    input  logic        ce,
    input  logic        sweepEnable,
    input  logic        realLock,
    input  logic        imagLock,
    input  logic [31:0] sweepRate,
    input  logic [15:0] sweepLimit,
    input  logic [15:0] lockCount,
    input  logic [15:0] unlockCount,
    output logic [15:0] sweepOffset,
    output logic        locked,
    output logic        loopReset,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSweep  = 2'd1,
        StVerify = 2'd2,
        StLocked = 2'd3
    } st_e;

    st_e         st;
    logic [31:0] acc;
    logic        dirUp;
    logic [15:0] cnt;

    logic               bothLock;
    logic [15:0]        limitMag;
    logic [15:0]        negLimit;
    logic signed [17:0] limitHi;
    logic signed [17:0] limitLo;
    logic [33:0]        accExt;
    logic [33:0]        rateExt;
    logic [33:0]        nextAcc;
    logic signed [17:0] nextHi;
    logic [15:0]        cntInc;
    logic [15:0]        lockTarget;
    logic [15:0]        unlockTarget;
    logic               unusedLimitMsb;

    // Sweep step, limit bounds and saturating dwell counter
    always_comb begin
        bothLock       = realLock & imagLock;
        unusedLimitMsb = sweepLimit[15];
        limitMag       = {1'b0, sweepLimit[14:0]};
        negLimit       = 16'd0 - limitMag;
        limitHi        = $signed({2'b00, limitMag});
        limitLo        = -limitHi;
        // Two guard bits so a full-scale rate can never wrap the trial sum
        accExt         = {{2{acc[31]}}, acc};
        rateExt        = {2'b00, sweepRate};
        nextAcc        = dirUp ? (accExt + rateExt) : (accExt - rateExt);
        nextHi         = $signed(nextAcc[33:16]);
        cntInc         = (cnt == 16'hFFFF) ? cnt : (cnt + 16'd1);
        lockTarget     = (lockCount == 16'd0) ? 16'd1 : lockCount;
        unlockTarget   = (unlockCount == 16'd0) ? 16'd1 : unlockCount;
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!nReset) begin
            st        <= StIdle;
            acc       <= 32'd0;
            dirUp     <= 1'b1;
            cnt       <= 16'd0;
            locked    <= 1'b0;
            loopReset <= 1'b0;
        end else begin
            loopReset <= 1'b0;
            if (!sweepEnable) begin
                // Abort does not wait for ce; the loop filter is cleared only if we held lock
                if (st == StLocked) begin
                    loopReset <= 1'b1;
                end
                st     <= StIdle;
                acc    <= 32'd0;
                dirUp  <= 1'b1;
                cnt    <= 16'd0;
                locked <= 1'b0;
            end else if (ce) begin
                unique case (st)
                    StIdle: begin
                        st <= StSweep;
                    end
                    StSweep: begin
                        if (bothLock) begin
                            st  <= StVerify;
                            cnt <= 16'd1;
                        end else if (dirUp && (nextHi >= limitHi)) begin
                            acc   <= {limitMag, 16'h0000};
                            dirUp <= 1'b0;
                        end else if (!dirUp && (nextHi <= limitLo)) begin
                            acc   <= {negLimit, 16'h0000};
                            dirUp <= 1'b1;
                        end else begin
                            acc <= nextAcc[31:0];
                        end
                    end
                    StVerify: begin
                        if (bothLock) begin
                            if (cntInc >= lockTarget) begin
                                st     <= StLocked;
                                locked <= 1'b1;
                                cnt    <= 16'd0;
                            end else begin
                                cnt <= cntInc;
                            end
                        end else begin
                            st  <= StSweep;
                            cnt <= 16'd0;
                        end
                    end
                    StLocked: begin
                        if (bothLock) begin
                            cnt <= 16'd0;
                        end else if (cntInc >= unlockTarget) begin
                            st        <= StSweep;
                            locked    <= 1'b0;
                            cnt       <= 16'd0;
                            loopReset <= 1'b1;
                        end else begin
                            cnt <= cntInc;
                        end
                    end
                endcase
            end
        end
    end

    assign sweepOffset = acc[31:16];
    assign state       = st;

endmodule

// File: tb/tb_combiner_sweep_ctrl.sv
// Directed self-checking bench for combiner_sweep_ctrl.
module tb_combiner_sweep_ctrl;

    logic        clk;
    logic        nReset;
    logic        ce;
    logic        sweepEnable;
    logic        realLock;
    logic        imagLock;
    logic [31:0] sweepRate;
    logic [15:0] sweepLimit;
    logic [15:0] lockCount;
    logic [15:0] unlockCount;
    logic [15:0] sweepOffset;
    logic        locked;
    logic        loopReset;
    logic [1:0]  state;

    int nCompared;
    int nMismatched;

    combiner_sweep_ctrl dut (
        .clk         (clk),
        .nReset      (nReset),
        .ce          (ce),
        .sweepEnable (sweepEnable),
        .realLock    (realLock),
        .imagLock    (imagLock),
        .sweepRate   (sweepRate),
        .sweepLimit  (sweepLimit),
        .lockCount   (lockCount),
        .unlockCount (unlockCount),
        .sweepOffset (sweepOffset),
        .locked      (locked),
        .loopReset   (loopReset),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setLock(input logic v);
        realLock = v;
        imagLock = v;
    endtask

    logic signed [15:0] triExp [14];
    logic [15:0]        expOff;
    logic [1:0]         expSt;

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        triExp = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd3, 16'sd2, 16'sd1, 16'sd0,
                   -16'sd1, -16'sd2, -16'sd3, -16'sd4, -16'sd3, -16'sd2};

        // Reset with random inputs
        nReset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ce          = 1'($urandom);
            sweepEnable = 1'($urandom);
            realLock    = 1'($urandom);
            imagLock    = 1'($urandom);
            sweepRate   = $urandom;
            sweepLimit  = 16'($urandom);
            lockCount   = 16'($urandom);
            unlockCount = 16'($urandom);
            tick();
        end
        checkVal("rst_offset", {16'h0, sweepOffset}, 32'h0);
        checkVal("rst_locked", {31'h0, locked}, 32'h0);
        checkVal("rst_loopreset", {31'h0, loopReset}, 32'h0);
        checkVal("rst_state", {30'h0, state}, 32'h0);

        nReset      = 1'b1;
        sweepEnable = 1'b0;
        ce          = 1'b1;
        setLock(1'b0);
        sweepRate   = 32'h0001_0000;
        sweepLimit  = 16'd4;
        lockCount   = 16'd3;
        unlockCount = 16'd2;
        tick();
        tick();
        checkVal("idle_hold_state", {30'h0, state}, 32'd0);

        // Triangle sweep
        sweepEnable = 1'b1;
        tick();
        checkVal("tri_enter_state", {30'h0, state}, 32'd1);
        checkVal("tri_enter_offset", {16'h0, sweepOffset}, 32'd0);
        for (int i = 0; i < 14; i++) begin
            tick();
            checkVal("tri_offset", {16'h0, sweepOffset}, {16'h0, triExp[i]});
        end

        // Zero limit keeps the offset pinned at zero
        sweepEnable = 1'b0;
        tick();
        checkVal("abort_idle_offset", {16'h0, sweepOffset}, 32'd0);
        sweepEnable = 1'b1;
        sweepLimit  = 16'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("zero_limit_offset", {16'h0, sweepOffset}, 32'd0);
        end

        // Acquisition: lock at offset 2, qualify on the 3rd lock ce
        sweepEnable = 1'b0;
        sweepLimit  = 16'h8004;    // bit 15 must be ignored
        tick();
        sweepEnable = 1'b1;
        tick();
        tick();
        tick();
        checkVal("acq_pre_offset", {16'h0, sweepOffset}, 32'd2);
        setLock(1'b1);
        tick();
        checkVal("acq_verify_state", {30'h0, state}, 32'd2);
        checkVal("acq_verify_offset", {16'h0, sweepOffset}, 32'd2);
        checkVal("acq_verify_locked", {31'h0, locked}, 32'd0);
        tick();
        checkVal("acq_verify2_state", {30'h0, state}, 32'd2);
        tick();
        checkVal("acq_locked_state", {30'h0, state}, 32'd3);
        checkVal("acq_locked_flag", {31'h0, locked}, 32'd1);
        checkVal("acq_locked_offset", {16'h0, sweepOffset}, 32'd2);
        tick();
        checkVal("acq_frozen_offset", {16'h0, sweepOffset}, 32'd2);

        // Unlock dwell: a one-ce glitch is tolerated, two ce drops unlock
        setLock(1'b0);
        tick();
        checkVal("glitch_state", {30'h0, state}, 32'd3);
        setLock(1'b1);
        tick();
        checkVal("glitch_restore_state", {30'h0, state}, 32'd3);
        setLock(1'b0);
        tick();
        checkVal("drop1_locked", {31'h0, locked}, 32'd1);
        tick();
        checkVal("unlock_state", {30'h0, state}, 32'd1);
        checkVal("unlock_locked", {31'h0, locked}, 32'd0);
        checkVal("unlock_loopreset", {31'h0, loopReset}, 32'd1);
        checkVal("unlock_offset", {16'h0, sweepOffset}, 32'd2);
        tick();
        checkVal("unlock_pulse_end", {31'h0, loopReset}, 32'd0);
        checkVal("resume_offset", {16'h0, sweepOffset}, 32'd3);

        // Lock lost on the 2nd ce: back to sweep without loopReset
        sweepEnable = 1'b0;
        tick();
        sweepEnable = 1'b1;
        tick();
        tick();
        tick();
        setLock(1'b1);
        tick();
        checkVal("short_verify_state", {30'h0, state}, 32'd2);
        setLock(1'b0);
        tick();
        checkVal("short_back_state", {30'h0, state}, 32'd1);
        checkVal("short_no_loopreset", {31'h0, loopReset}, 32'd0);
        checkVal("short_back_offset", {16'h0, sweepOffset}, 32'd2);
        tick();
        checkVal("short_cont3", {16'h0, sweepOffset}, 32'd3);
        tick();
        checkVal("short_cont4", {16'h0, sweepOffset}, 32'd4);

        // Enable abort from VERIFY, with ce low
        setLock(1'b1);
        tick();
        checkVal("abortv_pre_state", {30'h0, state}, 32'd2);
        sweepEnable = 1'b0;
        ce          = 1'b0;
        tick();
        checkVal("abortv_state", {30'h0, state}, 32'd0);
        checkVal("abortv_offset", {16'h0, sweepOffset}, 32'd0);
        checkVal("abortv_no_loopreset", {31'h0, loopReset}, 32'd0);

        // Enable abort from LOCKED, with ce low
        sweepEnable = 1'b1;
        ce          = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checkVal("abortl_pre_state", {30'h0, state}, 32'd3);
        sweepEnable = 1'b0;
        ce          = 1'b0;
        tick();
        checkVal("abortl_state", {30'h0, state}, 32'd0);
        checkVal("abortl_loopreset", {31'h0, loopReset}, 32'd1);
        checkVal("abortl_locked", {31'h0, locked}, 32'd0);
        tick();
        checkVal("abortl_pulse_end", {31'h0, loopReset}, 32'd0);

        // Gated ce: advance only on every 4th clock
        setLock(1'b0);
        sweepEnable = 1'b1;
        expOff = 16'd0;
        expSt  = 2'd0;
        for (int k = 0; k < 16; k++) begin
            ce = (k % 4 == 0);
            tick();
            if (ce) begin
                if (expSt == 2'd0) expSt = 2'd1;
                else expOff = expOff + 16'd1;
            end
            checkVal("gated_offset", {16'h0, sweepOffset}, {16'h0, expOff});
            checkVal("gated_state", {30'h0, state}, {30'h0, expSt});
        end

        // Saturating unlock dwell at the maximum count
        ce          = 1'b1;
        sweepEnable = 1'b0;
        tick();
        sweepEnable = 1'b1;
        setLock(1'b1);
        for (int i = 0; i < 4; i++) tick();
        checkVal("sat_locked_state", {30'h0, state}, 32'd3);
        unlockCount = 16'hFFFF;
        setLock(1'b0);
        for (int i = 0; i < 65534; i++) tick();
        checkVal("sat_still_locked", {31'h0, locked}, 32'd1);
        tick();
        checkVal("sat_unlock_state", {30'h0, state}, 32'd1);
        checkVal("sat_unlock_pulse", {31'h0, loopReset}, 32'd1);

        // Reset mid-operation wins
        nReset = 1'b0;
        tick();
        checkVal("midrst_state", {30'h0, state}, 32'd0);
        checkVal("midrst_offset", {16'h0, sweepOffset}, 32'd0);
        checkVal("midrst_loopreset", {31'h0, loopReset}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
